// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end.
// control_unit's decoders reuse these to extract instruction fields.
package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      ISSUE = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] INSTR_NOP = 32'hE1A0_0000;

   localparam int unsigned COND_LSB  = 28;
   localparam int unsigned OP_LSB    = 26;
   localparam int unsigned FUNCT_LSB = 20;
   localparam int unsigned RN_LSB    = 16;
   localparam int unsigned RD_LSB    = 12;
   localparam int unsigned RM_LSB    = 0;
   localparam int unsigned IMM12_LSB = 0;

endpackage

// File: rtl/instr_fetch_unit_field_split.sv
// Combinational split of an instruction word into decoder fields.
module instr_field_split
   import instr_fetch_unit_pkg::*;
(
   input  logic [31:0] instr,
   output logic [3:0]  cond,
   output logic [1:0]  op,
   output logic [5:0]  funct,
   output logic [3:0]  rn,
   output logic [3:0]  rd,
   output logic [3:0]  rm,
   output logic [11:0] imm12
);

   assign cond  = instr[COND_LSB  +: 4];
   assign op    = instr[OP_LSB    +: 2];
   assign funct = instr[FUNCT_LSB +: 6];
   assign rn    = instr[RN_LSB    +: 4];
   assign rd    = instr[RD_LSB    +: 4];
   assign rm    = instr[RM_LSB    +: 4];
   assign imm12 = instr[IMM12_LSB +: 12];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack handshake,
// holds the instruction register and counts retired instructions.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned TIMEOUT      = 16,
   parameter logic [31:0] INSTR_NOP    = instr_fetch_unit_pkg::INSTR_NOP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_stall,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_target,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic        o_instr_valid,
   output logic [31:0] o_instr,
   output logic [3:0]  o_cond,
   output logic [1:0]  o_op,
   output logic [5:0]  o_funct,
   output logic [3:0]  o_rn,
   output logic [3:0]  o_rd,
   output logic [3:0]  o_rm,
   output logic [11:0] o_imm12,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus8,
   output logic [31:0] o_retired,
   output logic        o_fetch_err
);
   import instr_fetch_unit_pkg::*;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [7:0]   tmo_cnt;

   // Fetch/issue/halt sequencing with PC, instruction register and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= FETCH;
         pc            <= RESET_VECTOR;
         tmo_cnt       <= '0;
         o_instr       <= INSTR_NOP;
         o_instr_valid <= 1'b0;
         o_retired     <= '0;
         o_fetch_err   <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (i_imem_ack) begin
                  o_instr       <= i_imem_rdata;
                  o_instr_valid <= 1'b1;
                  tmo_cnt       <= '0;
                  state         <= ISSUE;
               end else if (tmo_cnt == TMO_LAST) begin
                  o_fetch_err <= 1'b1;
                  state       <= HALT;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            ISSUE: begin
               if (!i_stall) begin
                  o_retired     <= o_retired + 32'd1;
                  o_instr_valid <= 1'b0;
                  state         <= FETCH;
                  pc            <= i_branch_taken ? (i_branch_target & ~32'd3)
                                                  : pc + 32'd4;
               end
            end
            default: begin
               // HALT (and any unused encoding) waits for reset
            end
         endcase
      end
   end

   // Request is gated by rst so it drops the moment reset asserts
   assign o_imem_req  = (state == FETCH) && !rst;
   assign o_imem_addr = pc;
   assign o_pc        = pc;
   assign o_pc_plus8  = pc + 32'd8;

   instr_field_split u_field_split (
      .instr (o_instr),
      .cond  (o_cond),
      .op    (o_op),
      .funct (o_funct),
      .rn    (o_rn),
      .rd    (o_rd),
      .rm    (o_rm),
      .imm12 (o_imm12)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus
// randomized fetch/issue transactions against a transaction-level model.
module tb_instr_fetch_unit;

   localparam int unsigned TMO = 16;
   localparam logic [31:0] NOP = 32'hE1A0_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_stall;
   logic        i_branch_taken;
   logic [31:0] i_branch_target;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic [31:0] i_imem_rdata;
   logic        o_instr_valid;
   logic [31:0] o_instr;
   logic [3:0]  o_cond;
   logic [1:0]  o_op;
   logic [5:0]  o_funct;
   logic [3:0]  o_rn;
   logic [3:0]  o_rd;
   logic [3:0]  o_rm;
   logic [11:0] o_imm12;
   logic [31:0] o_pc;
   logic [31:0] o_pc_plus8;
   logic [31:0] o_retired;
   logic        o_fetch_err;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Reference model state: architectural PC and retired count
   logic [31:0] m_pc;
   logic [31:0] m_retired;

   instr_fetch_unit #(
      .RESET_VECTOR (32'h0000_0000),
      .TIMEOUT      (TMO),
      .INSTR_NOP    (NOP)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_stall         (i_stall),
      .i_branch_taken  (i_branch_taken),
      .i_branch_target (i_branch_target),
      .o_imem_req      (o_imem_req),
      .o_imem_addr     (o_imem_addr),
      .i_imem_ack      (i_imem_ack),
      .i_imem_rdata    (i_imem_rdata),
      .o_instr_valid   (o_instr_valid),
      .o_instr         (o_instr),
      .o_cond          (o_cond),
      .o_op            (o_op),
      .o_funct         (o_funct),
      .o_rn            (o_rn),
      .o_rd            (o_rd),
      .o_rm            (o_rm),
      .o_imm12         (o_imm12),
      .o_pc            (o_pc),
      .o_pc_plus8      (o_pc_plus8),
      .o_retired       (o_retired),
      .o_fetch_err     (o_fetch_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic check_reset_values();
      check_eq("rst_req",     32'(o_imem_req),    32'd0);
      check_eq("rst_addr",    o_imem_addr,        32'h0);
      check_eq("rst_valid",   32'(o_instr_valid), 32'd0);
      check_eq("rst_instr",   o_instr,            NOP);
      check_eq("rst_retired", o_retired,          32'd0);
      check_eq("rst_err",     32'(o_fetch_err),   32'd0);
   endtask

   // Memory side: serve the pending request after 'delay' idle cycles, then
   // check the issued instruction. Stall/branch inputs are randomized here
   // since they must be ignored while fetching.
   task automatic fetch(input int unsigned delay, input logic [31:0] data);
      logic [31:0] w;
      for (int unsigned i = 0; i <= delay; i++) begin
         @(negedge clk);
         check_eq("f_req",     32'(o_imem_req),    32'd1);
         check_eq("f_addr",    o_imem_addr,        m_pc);
         check_eq("f_valid",   32'(o_instr_valid), 32'd0);
         check_eq("f_err",     32'(o_fetch_err),   32'd0);
         check_eq("f_retired", o_retired,          m_retired);
         i_stall         = 1'($urandom);
         i_branch_taken  = 1'($urandom);
         i_branch_target = $urandom;
         i_imem_ack      = (i == delay);
         i_imem_rdata    = (i == delay) ? data : $urandom;
      end
      @(negedge clk);
      i_imem_ack = 1'b0;
      w = data;
      check_eq("i_valid", 32'(o_instr_valid), 32'd1);
      check_eq("i_req",   32'(o_imem_req),    32'd0);
      check_eq("i_instr", o_instr,            w);
      check_eq("i_cond",  32'(o_cond),        32'(w[31:28]));
      check_eq("i_op",    32'(o_op),          32'(w[27:26]));
      check_eq("i_funct", 32'(o_funct),       32'(w[25:20]));
      check_eq("i_rn",    32'(o_rn),          32'(w[19:16]));
      check_eq("i_rd",    32'(o_rd),          32'(w[15:12]));
      check_eq("i_rm",    32'(o_rm),          32'(w[3:0]));
      check_eq("i_imm12", 32'(o_imm12),       32'(w[11:0]));
      check_eq("i_pc",    o_pc,               m_pc);
      check_eq("i_pc8",   o_pc_plus8,         m_pc + 32'd8);
   endtask

   // Downstream side: stall for 'stalls' cycles with noisy branch inputs, then
   // retire with the given branch decision and advance the model.
   task automatic issue(input int unsigned stalls, input logic taken, input logic [31:0] tgt);
      logic [31:0] held;
      held = o_instr;
      for (int unsigned s = 0; s < stalls; s++) begin
         i_stall         = 1'b1;
         i_branch_taken  = 1'($urandom);
         i_branch_target = $urandom;
         @(negedge clk);
         check_eq("s_valid",   32'(o_instr_valid), 32'd1);
         check_eq("s_instr",   o_instr,            held);
         check_eq("s_pc",      o_pc,               m_pc);
         check_eq("s_retired", o_retired,          m_retired);
         check_eq("s_req",     32'(o_imem_req),    32'd0);
      end
      i_stall         = 1'b0;
      i_branch_taken  = taken;
      i_branch_target = tgt;
      m_pc      = taken ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
      m_retired = m_retired + 32'd1;
   endtask

   initial begin
      rst = 1'b1; i_stall = 1'b0; i_branch_taken = 1'b0; i_branch_target = '0;
      i_imem_ack = 1'b0; i_imem_rdata = '0;
      m_pc = 32'h0; m_retired = 32'd0;
      #1;
      check_reset_values();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rel_req",  32'(o_imem_req), 32'd1);
      check_eq("rel_addr", o_imem_addr,     32'h0);

      // Basic fetch, decode and retire
      fetch(0, 32'hE281_1001);
      check_eq("t1_cond",  32'(o_cond),  32'hE);
      check_eq("t1_funct", 32'(o_funct), 32'b101000);
      issue(0, 1'b0, 32'h0);
      // Delayed ack, then long stall with toggling branch
      fetch(3, $urandom);
      issue(5, 1'b0, 32'h0);

      // Reset during second cycle of a pending fetch at PC=8
      @(negedge clk);
      check_eq("r_addr8", o_imem_addr, 32'h8);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_values();
      i_imem_ack = 1'b1; i_imem_rdata = $urandom;
      @(negedge clk);
      check_reset_values();
      i_imem_ack = 1'b0;
      rst = 1'b0;
      m_pc = 32'h0; m_retired = 32'd0;
      #1;
      check_eq("r_req",   32'(o_imem_req),    32'd1);
      check_eq("r_valid", 32'(o_instr_valid), 32'd0);

      // Branch to an unaligned target
      fetch($urandom_range(0, 4), $urandom);
      issue(0, 1'b1, 32'h0000_0103);
      fetch(0, $urandom);
      check_eq("b_pc8", o_pc_plus8, 32'h108);
      issue(1, 1'b0, 32'h0);

      // Ack on the very last cycle before timeout must still succeed
      fetch(TMO - 1, $urandom);
      issue(0, 1'b0, 32'h0);

      // Randomized transactions
      for (int unsigned t = 0; t < 40; t++) begin
         fetch($urandom_range(0, 6), $urandom);
         issue($urandom_range(0, 3), 1'($urandom), $urandom);
      end

      // Timeout: no ack for TMO request cycles
      for (int unsigned c = 0; c < TMO; c++) begin
         @(negedge clk);
         check_eq("to_req",  32'(o_imem_req),  32'd1);
         check_eq("to_err",  32'(o_fetch_err), 32'd0);
         check_eq("to_addr", o_imem_addr,      m_pc);
      end
      @(negedge clk);
      check_eq("h_err", 32'(o_fetch_err), 32'd1);
      check_eq("h_req", 32'(o_imem_req),  32'd0);
      i_imem_ack = 1'b1; i_imem_rdata = $urandom;
      repeat (3) begin
         @(negedge clk);
         check_eq("h_req_hold",   32'(o_imem_req),    32'd0);
         check_eq("h_valid_hold", 32'(o_instr_valid), 32'd0);
         check_eq("h_err_hold",   32'(o_fetch_err),   32'd1);
         check_eq("h_retired",    o_retired,          m_retired);
      end
      i_imem_ack = 1'b0;

      // Only reset leaves HALT
      rst = 1'b1;
      #1;
      check_reset_values();
      @(negedge clk);
      rst = 1'b0;
      m_pc = 32'h0; m_retired = 32'd0;
      fetch(1, $urandom);
      issue(0, 1'b0, 32'h0);
      @(negedge clk);
      check_eq("end_addr",    o_imem_addr, 32'h4);
      check_eq("end_retired", o_retired,   32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
